// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: parametrised UART receiver with a one-cycle valid strobe and parity/framing error flags.
// Ports: clk; rst_n (synchronous, active low); i_rx (async serial line, idle high);
//   o_data / o_parity_err / o_frame_err (result of the last frame, updated with o_valid);
//   o_valid (one-cycle strobe); o_busy (high from start-edge detection until back in S_IDLE).
// Option: define UART_RX_MAJORITY_EN to take every bit as the 2-of-3 majority around its centre.
module uart_rx_cfg #(
  parameter int CLK_PER_BIT = 868,
  parameter int DATA_BITS   = 8,
  parameter int PARITY      = 0,
  parameter int STOP_BITS   = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_rx,
  output logic [DATA_BITS-1:0] o_data,
  output logic                 o_valid,
  output logic                 o_parity_err,
  output logic                 o_frame_err,
  output logic                 o_busy
);
`ifdef UART_RX_MAJORITY_EN
  localparam int MIN_CPB = 8;
  localparam int DLY     = 1;
`else
  localparam int MIN_CPB = 4;
  localparam int DLY     = 0;
`endif
  localparam int CW       = $clog2(CLK_PER_BIT);
  localparam int IW       = $clog2(DATA_BITS);
  localparam int HALF     = (CLK_PER_BIT - 1) / 2;
  localparam int START_PT = HALF + DLY;

  if (CLK_PER_BIT < MIN_CPB || DATA_BITS < 5 || DATA_BITS > 9 || PARITY < 0 || PARITY > 2 ||
      STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_param
    $error("uart_rx_cfg: illegal parameter value");
  end

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK} state_t;

  state_t               state;
  logic                 rx_m, rx_s, bit_v;
  logic [CW-1:0]        cnt;
  logic [IW-1:0]        bit_idx;
  logic [DATA_BITS-1:0] data;
  logic                 perr, ferr;
  logic                 bit_tick, start_tick, last_bad;

  always_ff @(posedge clk) begin
    if (!rst_n) {rx_s, rx_m} <= 2'b11;
    else        {rx_s, rx_m} <= {rx_m, i_rx};
  end

`ifdef UART_RX_MAJORITY_EN
  // hist holds rx_s at centre-1 and centre when the decision is taken at centre+1
  logic [1:0] hist;
  always_ff @(posedge clk) begin
    if (!rst_n) hist <= 2'b11;
    else        hist <= {hist[0], rx_s};
  end
  assign bit_v = (hist[1] & hist[0]) | (hist[1] & rx_s) | (hist[0] & rx_s);
`else
  assign bit_v = rx_s;
`endif

  // every later decision falls a full bit period after the start-bit decision,
  // so the majority delay shifts all of them uniformly
  assign bit_tick   = cnt == CW'(CLK_PER_BIT - 1);
  assign start_tick = cnt == CW'(START_PT);
  assign last_bad   = ferr | ~bit_v;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      cnt          <= '0;
      bit_idx      <= '0;
      data         <= '0;
      perr         <= 1'b0;
      ferr         <= 1'b0;
      o_data       <= '0;
      o_valid      <= 1'b0;
      o_parity_err <= 1'b0;
      o_frame_err  <= 1'b0;
      o_busy       <= 1'b0;
    end else begin
      o_valid <= 1'b0;
      cnt     <= bit_tick ? '0 : cnt + 1'b1;
      case (state)
        S_IDLE: begin
          cnt <= '0;
          if (!rx_s) begin
            state  <= S_START;
            o_busy <= 1'b1;
          end
        end
        S_START: if (start_tick) begin
          cnt     <= '0;
          bit_idx <= '0;
          perr    <= 1'b0;
          ferr    <= 1'b0;
          if (bit_v) begin
            state  <= S_IDLE;
            o_busy <= 1'b0;
          end else state <= S_DATA;
        end
        S_DATA: if (bit_tick) begin
          data    <= {bit_v, data[DATA_BITS-1:1]};
          bit_idx <= bit_idx + 1'b1;
          if (bit_idx == IW'(DATA_BITS - 1)) begin
            bit_idx <= '0;
            state   <= (PARITY != 0) ? S_PARITY : S_STOP;
          end
        end
        S_PARITY: if (bit_tick) begin
          perr  <= (^data ^ bit_v) != (PARITY == 1);
          state <= S_STOP;
        end
        S_STOP: if (bit_tick) begin
          bit_idx <= bit_idx + 1'b1;
          ferr    <= last_bad;
          // strobe at the last stop centre so an immediately following start bit is seen
          if (bit_idx == IW'(STOP_BITS - 1)) begin
            o_data       <= data;
            o_parity_err <= perr;
            o_frame_err  <= last_bad;
            o_valid      <= 1'b1;
            o_busy       <= last_bad;
            state        <= last_bad ? S_BREAK : S_IDLE;
          end
        end
        S_BREAK: if (rx_s) begin
          state  <= S_IDLE;
          o_busy <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
